// File: rtl/branch_pc_unit.sv
// Branch resolution and fetch PC register.
// Decides taken branches/jumps, redirects fetch and squashes IF/ID.
module branch_pc_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          CNT_W        = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_stall,
   input  logic             i_ex_valid,
   input  logic             i_is_branch,
   input  logic             i_is_jal,
   input  logic             i_is_jalr,
   input  logic [2:0]       i_funct3,
   input  logic             i_br_less,
   input  logic             i_br_equal,
   input  logic [31:0]      i_target,
   output logic             o_br_un,
   output logic [31:0]      o_pc,
   output logic [31:0]      o_pc_four,
   output logic             o_flush,
   output logic             o_misalign,
   output logic [CNT_W-1:0] o_taken_cnt
);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [2:0]       fcnt;
   logic [31:0]      pc;
   logic             misalign_q;
   logic [CNT_W-1:0] taken_cnt;

   logic             cond;
   logic             xfer;
   logic             take;
   logic             redirect;
   logic             misalign;
   logic [31:0]      eff_target;
   logic [31:0]      pc_four;

   // Comparator mode select from EX funct3 (100/101 choose mode 1).
   always_comb begin
      o_br_un = 1'b0;
      unique case (i_funct3)
         3'b100,
         3'b101:  o_br_un = 1'b1;
         default: o_br_un = 1'b0;
      endcase
   end

   // Branch condition from comparator flags.
   always_comb begin
      cond = 1'b0;
      unique case (i_funct3)
         3'b000:  cond = i_br_equal;
         3'b001:  cond = !i_br_equal;
         3'b100,
         3'b110:  cond = i_br_less;
         3'b101,
         3'b111:  cond = !i_br_less;
         default: cond = 1'b0;
      endcase
   end

   // Control-transfer decision by instruction class.
   always_comb begin
      xfer = 1'b0;
      unique case (1'b1)
         i_is_jal:    xfer = 1'b1;
         i_is_jalr:   xfer = 1'b1;
         i_is_branch: xfer = cond;
         default:     xfer = 1'b0;
      endcase
   end

   // JALR clears bit 0; others use the ALU target directly.
   always_comb begin
      eff_target = i_target;
      if (i_is_jalr) begin
         eff_target = {i_target[31:1], 1'b0};
      end
   end

   assign take     = i_ex_valid && (state == RUN) && xfer;
   assign redirect = take && (eff_target[1:0] == 2'b00);
   assign misalign = take && (eff_target[1:0] != 2'b00);
   assign pc_four  = pc + 32'd4;

   // Fetch PC, flush FSM, misalign pulse and redirect counter.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= RUN;
         fcnt       <= 3'd0;
         pc         <= RESET_PC;
         misalign_q <= 1'b0;
         taken_cnt  <= '0;
      end else begin
         misalign_q <= 1'b0;
         unique case (state)
            RUN: begin
               if (redirect) begin
                  pc        <= eff_target;
                  fcnt      <= FLUSH_INIT;
                  state     <= FLUSH;
                  taken_cnt <= taken_cnt + CNT_ONE;
               end else begin
                  misalign_q <= misalign;
                  if (!i_stall) begin
                     pc <= pc_four;
                  end
               end
            end
            FLUSH: begin
               if (!i_stall) begin
                  pc <= pc_four;
                  if (fcnt == 3'd0) begin
                     state <= RUN;
                  end else begin
                     fcnt <= fcnt - 3'd1;
                  end
               end
            end
            default: begin
               state <= RUN;
               fcnt  <= 3'd0;
            end
         endcase
      end
   end

   assign o_pc        = pc;
   assign o_pc_four   = pc_four;
   assign o_flush     = (state == FLUSH);
   assign o_misalign  = misalign_q;
   assign o_taken_cnt = taken_cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: scoreboard of per-cycle expectations
// produced by an independent model, plus directed constant checks.
module tb_branch_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          FC     = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        ex_valid;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic [2:0]  funct3;
   logic        br_less;
   logic        br_equal;
   logic [31:0] target;
   logic        br_un;
   logic [31:0] pc;
   logic [31:0] pc_four;
   logic        flush;
   logic        misalign;
   logic [31:0] taken_cnt;

   always #5 clk = ~clk;

   branch_pc_unit #(
      .RESET_PC    (RST_PC),
      .FLUSH_CYCLES(FC),
      .CNT_W       (32)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_stall    (stall),
      .i_ex_valid (ex_valid),
      .i_is_branch(is_branch),
      .i_is_jal   (is_jal),
      .i_is_jalr  (is_jalr),
      .i_funct3   (funct3),
      .i_br_less  (br_less),
      .i_br_equal (br_equal),
      .i_target   (target),
      .o_br_un    (br_un),
      .o_pc       (pc),
      .o_pc_four  (pc_four),
      .o_flush    (flush),
      .o_misalign (misalign),
      .o_taken_cnt(taken_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic        flush;
      logic        mis;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_err    = 0;

   // model state: flush_left = remaining flush cycles (0 = running)
   logic [31:0] m_pc;
   int          m_left;
   logic        m_mis;
   logic [31:0] m_cnt;
   bit          m_init = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic model_cond(input logic [2:0] f,
                                       input logic lt, input logic eq);
      if (f[2])      return lt ^ f[0];
      else if (f[1]) return 1'b0;
      else           return eq ^ f[0];
   endfunction

   task automatic model_step();
      logic        xf;
      logic [31:0] t;
      if (!rst_n) begin
         m_pc   = RST_PC;
         m_left = 0;
         m_mis  = 1'b0;
         m_cnt  = 32'd0;
      end else if (m_left == 0) begin
         xf = ex_valid && (is_jal || is_jalr ||
              (is_branch && model_cond(funct3, br_less, br_equal)));
         t  = is_jalr ? (target & 32'hFFFF_FFFE) : target;
         m_mis = 1'b0;
         if (xf && t[1:0] == 2'b00) begin
            m_pc   = t;
            m_left = FC;
            m_cnt  = m_cnt + 1;
         end else begin
            m_mis = xf;
            if (!stall) m_pc = m_pc + 32'd4;
         end
      end else begin
         m_mis = 1'b0;
         if (!stall) begin
            m_pc   = m_pc + 32'd4;
            m_left = m_left - 1;
         end
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic v,
                        input logic b, input logic j, input logic jr,
                        input logic [2:0] f3, input logic lt,
                        input logic eq, input logic [31:0] tg);
      exp_t e;
      exp_t o;
      rst_n = r; stall = s; ex_valid = v;
      is_branch = b; is_jal = j; is_jalr = jr;
      funct3 = f3; br_less = lt; br_equal = eq; target = tg;
      #1;
      check("br_un", {31'd0, br_un},
            {31'd0, (f3 == 3'b100 || f3 == 3'b101)});
      if (m_init) check("pc_four", pc_four, m_pc + 32'd4);
      model_step();
      m_init = 1;
      e.pc = m_pc; e.flush = (m_left != 0);
      e.mis = m_mis; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         o = sb.pop_front();
         check("pc", pc, o.pc);
         check("flush", {31'd0, flush}, {31'd0, o.flush});
         check("misalign", {31'd0, misalign}, {31'd0, o.mis});
         check("taken_cnt", taken_cnt, o.cnt);
      end
   endtask

   task automatic idle(input int n, input logic s);
      for (int i = 0; i < n; i++)
         drive(1, s, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
   endtask

   initial begin
      rst_n = 0; stall = 0; ex_valid = 0; is_branch = 0;
      is_jal = 0; is_jalr = 0; funct3 = 0; br_less = 0;
      br_equal = 0; target = 0;
      @(posedge clk);
      #1;
      // reset
      drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
      drive(0, 1, 1, 0, 1, 0, 3'b000, 0, 0, 32'h80);
      check("rst_pc", pc, 32'h0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      // sequential fetch
      idle(5, 0);
      check("seq_pc", pc, 32'h14);
      // BLT taken to 0x100
      drive(1, 0, 1, 1, 0, 0, 3'b100, 1, 0, 32'h100);
      check("blt_pc", pc, 32'h100);
      check("blt_flush", {31'd0, flush}, 32'd1);
      idle(2, 0);
      check("blt_pc2", pc, 32'h108);
      check("blt_flush2", {31'd0, flush}, 32'd0);
      check("blt_cnt", taken_cnt, 32'd1);
      // BGEU not taken, then taken
      drive(1, 0, 1, 1, 0, 0, 3'b111, 1, 0, 32'h40);
      check("bgeu_nt", pc, 32'h10C);
      drive(1, 0, 1, 1, 0, 0, 3'b111, 0, 0, 32'h40);
      check("bgeu_t", pc, 32'h40);
      idle(2, 0);
      // other branch kinds, including never-taken 010/011
      drive(1, 0, 1, 1, 0, 0, 3'b010, 1, 1, 32'h80);
      drive(1, 0, 1, 1, 0, 0, 3'b011, 0, 0, 32'h80);
      drive(1, 0, 1, 1, 0, 0, 3'b001, 0, 0, 32'h80);
      idle(2, 0);
      // JALR misaligned, then aligned after bit-0 clear
      drive(1, 0, 1, 0, 0, 1, 3'b000, 0, 0, 32'h203);
      check("jalr_mis", {31'd0, misalign}, 32'd1);
      check("jalr_mis_fl", {31'd0, flush}, 32'd0);
      idle(1, 0);
      check("jalr_mis_1c", {31'd0, misalign}, 32'd0);
      drive(1, 0, 1, 0, 0, 1, 3'b000, 0, 0, 32'h201);
      check("jalr_pc", pc, 32'h200);
      idle(2, 0);
      // redirect while stalled, hold stall 3 cycles
      drive(1, 1, 1, 0, 1, 0, 3'b000, 0, 0, 32'h300);
      check("stall_tgt", pc, 32'h300);
      idle(3, 1);
      check("stall_hold", pc, 32'h300);
      check("stall_fl", {31'd0, flush}, 32'd1);
      idle(1, 0);
      check("rel_fl1", {31'd0, flush}, 32'd1);
      idle(1, 0);
      check("rel_fl2", {31'd0, flush}, 32'd0);
      // branch during flush is ignored
      drive(1, 0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h400);
      drive(1, 0, 1, 1, 0, 0, 3'b000, 0, 1, 32'h500);
      check("fl_ign_pc", pc, 32'h404);
      idle(2, 0);
      // misaligned branch while stalled: PC holds
      drive(1, 1, 1, 1, 0, 0, 3'b000, 0, 1, 32'h502);
      // reset mid-flush
      drive(1, 0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h600);
      drive(0, 1, 1, 0, 1, 0, 3'b000, 0, 0, 32'h700);
      check("rstfl_pc", pc, RST_PC);
      check("rstfl_fl", {31'd0, flush}, 32'd0);
      // PC wrap
      drive(1, 0, 1, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFF8);
      idle(3, 0);
      check("wrap_pc", pc, 32'h4);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         int c;
         logic [31:0] tg;
         c  = $urandom_range(0, 3);
         tg = $urandom;
         if ($urandom_range(0, 1) == 0) tg[1:0] = 2'b00;
         drive(($urandom_range(0, 40) != 0),
               ($urandom_range(0, 3) == 0),
               $urandom_range(0, 1),
               (c == 1), (c == 2), (c == 3),
               3'($urandom_range(0, 7)),
               $urandom_range(0, 1), $urandom_range(0, 1), tg);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
